// File: rtl/cva6_tlb_sv32_pkg.sv
// Shared Sv32 types for the fully associative TLB: PTE layout, refill packet and entry tag.
package cva6_tlb_sv32_pkg;

  localparam int unsigned VPN_W      = 10;
  localparam int unsigned PPN_W      = 22;
  localparam int unsigned ASID_MAX_W = 9;
  localparam int unsigned PTE_W      = 32;
  localparam int unsigned UPDATE_W   = 63;

  typedef struct packed {
    logic [PPN_W-1:0] ppn;
    logic [1:0]       rsw;
    logic             d;
    logic             a;
    logic             g;
    logic             u;
    logic             x;
    logic             w;
    logic             r;
    logic             v;
  } pte_t;

  typedef struct packed {
    logic                  valid;
    logic                  is_4M;
    logic [VPN_W-1:0]      vpn1;
    logic [VPN_W-1:0]      vpn0;
    logic [ASID_MAX_W-1:0] asid;
    pte_t                  content;
  } update_t;

  typedef struct packed {
    logic                  valid;
    logic                  is_4M;
    logic [VPN_W-1:0]      vpn1;
    logic [VPN_W-1:0]      vpn0;
    logic [ASID_MAX_W-1:0] asid;
  } tag_t;

endpackage

// File: rtl/tlb_plru_tree.sv
// Tree pseudo-LRU replacement state: ENTRIES-1 heap-ordered node bits, 1 = upper half is the victim side.
module tlb_plru_tree #(
  parameter int unsigned ENTRIES = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       access_i,
  input  logic [$clog2(ENTRIES)-1:0] access_idx_i,
  output logic [$clog2(ENTRIES)-1:0] victim_o
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-2:0] nodes_q, nodes_d;

  // Every node on the accessed entry's path is turned to point at the other half.
  always_comb begin
    int node;
    nodes_d = nodes_q;
    node    = 0;
    if (access_i) begin
      for (int l = 0; l < int'(IDX_W); l++) begin
        node = (1 << l) - 1 + (int'(access_idx_i) >> (int'(IDX_W) - l));
        nodes_d[node] = ~access_idx_i[int'(IDX_W) - 1 - l];
      end
    end
  end

  always_comb begin
    int node;
    node     = 0;
    victim_o = '0;
    for (int l = 0; l < int'(IDX_W); l++) begin
      victim_o[int'(IDX_W) - 1 - l] = nodes_q[node];
      node = 2 * node + 1 + int'(nodes_q[node]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nodes_q <= '0;
    end else begin
      nodes_q <= nodes_d;
    end
  end

endmodule

// File: rtl/cva6_tlb_sv32.sv
// Fully associative Sv32 TLB: combinational lookup, ASID/address flush, refill into lowest free or PLRU entry.
module cva6_tlb_sv32
  import cva6_tlb_sv32_pkg::*;
#(
  parameter int unsigned TLB_ENTRIES = 4,
  parameter int unsigned ASID_WIDTH  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [UPDATE_W-1:0]   update_i,
  input  logic                  lu_access_i,
  input  logic [ASID_WIDTH-1:0] lu_asid_i,
  input  logic [31:0]           lu_vaddr_i,
  output logic [PTE_W-1:0]      lu_content_o,
  input  logic [ASID_WIDTH-1:0] asid_to_be_flushed_i,
  input  logic [31:0]           vaddr_to_be_flushed_i,
  output logic                  lu_is_4M_o,
  output logic                  lu_hit_o
);
  localparam int unsigned IDX_W = $clog2(TLB_ENTRIES);
  localparam logic [ASID_MAX_W-1:0] ASID_MASK = ASID_MAX_W'((1 << ASID_WIDTH) - 1);

  update_t                upd;
  tag_t                   tags_q    [TLB_ENTRIES];
  tag_t                   tags_d    [TLB_ENTRIES];
  pte_t                   content_q [TLB_ENTRIES];
  pte_t                   content_d [TLB_ENTRIES];
  logic [TLB_ENTRIES-1:0] lu_hit;
  logic [TLB_ENTRIES-1:0] flush_hit;
  logic [IDX_W-1:0]       hit_idx, plru_victim, free_idx, victim;
  logic                   all_valid, flush_asid_zero, flush_vaddr_zero;
  logic                   unused_page_offset;

  assign upd                = update_i;
  assign unused_page_offset = ^lu_vaddr_i[11:0];
  assign flush_asid_zero    = (asid_to_be_flushed_i == '0);
  assign flush_vaddr_zero   = (vaddr_to_be_flushed_i == '0);

  always_comb begin
    for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
      lu_hit[i] = tags_q[i].valid
                  && ((tags_q[i].asid == ASID_MAX_W'(lu_asid_i)) || content_q[i].g)
                  && (tags_q[i].vpn1 == lu_vaddr_i[31:22])
                  && (tags_q[i].is_4M || (tags_q[i].vpn0 == lu_vaddr_i[21:12]));
    end
  end

  // Later entries overwrite earlier ones, so the highest hitting index wins.
  always_comb begin
    lu_hit_o     = 1'b0;
    lu_content_o = '0;
    lu_is_4M_o   = 1'b0;
    hit_idx      = '0;
    for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
      if (lu_hit[i]) begin
        lu_hit_o     = 1'b1;
        lu_content_o = content_q[i];
        lu_is_4M_o   = tags_q[i].is_4M;
        hit_idx      = IDX_W'(i);
      end
    end
  end

  always_comb begin
    logic addr_m, asid_m;
    for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
      addr_m = (tags_q[i].vpn1 == vaddr_to_be_flushed_i[31:22])
               && (tags_q[i].is_4M || (tags_q[i].vpn0 == vaddr_to_be_flushed_i[21:12]));
      asid_m = (tags_q[i].asid == ASID_MAX_W'(asid_to_be_flushed_i));
      unique case ({flush_asid_zero, flush_vaddr_zero})
        2'b11:   flush_hit[i] = 1'b1;
        2'b10:   flush_hit[i] = addr_m;
        2'b01:   flush_hit[i] = asid_m && !content_q[i].g;
        default: flush_hit[i] = addr_m && asid_m && !content_q[i].g;
      endcase
    end
  end

  // Scanning downward leaves the lowest invalid index in free_idx.
  always_comb begin
    all_valid = 1'b1;
    free_idx  = '0;
    for (int i = int'(TLB_ENTRIES) - 1; i >= 0; i--) begin
      if (!tags_q[i].valid) begin
        all_valid = 1'b0;
        free_idx  = IDX_W'(i);
      end
    end
  end

  assign victim = all_valid ? plru_victim : free_idx;

  always_comb begin
    tags_d    = tags_q;
    content_d = content_q;
    if (flush_i) begin
      for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
        if (flush_hit[i]) tags_d[i].valid = 1'b0;
      end
    end else if (upd.valid) begin
      tags_d[victim].valid = 1'b1;
      tags_d[victim].is_4M = upd.is_4M;
      tags_d[victim].vpn1  = upd.vpn1;
      tags_d[victim].vpn0  = upd.vpn0;
      tags_d[victim].asid  = upd.asid & ASID_MASK;
      content_d[victim]    = upd.content;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
        tags_q[i]    <= '0;
        content_q[i] <= '0;
      end
    end else begin
      tags_q    <= tags_d;
      content_q <= content_d;
    end
  end

  tlb_plru_tree #(
    .ENTRIES (TLB_ENTRIES)
  ) i_plru (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .access_i     (lu_access_i && lu_hit_o),
    .access_idx_i (hit_idx),
    .victim_o     (plru_victim)
  );

endmodule

// File: tb/tb_cva6_tlb_sv32.sv
// Bench for cva6_tlb_sv32: directed scenarios with literal expectations plus a randomized run against a behavioural model.
module tb_cva6_tlb_sv32;
  localparam int N   = 4;
  localparam int LOG = 2;
  localparam int AW  = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [62:0]   update = '0;
  logic          lu_access = 1'b0;
  logic [AW-1:0] lu_asid = '0;
  logic [31:0]   lu_vaddr = '0;
  logic [AW-1:0] fl_asid = '0;
  logic [31:0]   fl_vaddr = '0;
  logic [31:0]   lu_content;
  logic          lu_is_4M;
  logic          lu_hit;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cva6_tlb_sv32 #(
    .TLB_ENTRIES (N),
    .ASID_WIDTH  (AW)
  ) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .flush_i               (flush),
    .update_i              (update),
    .lu_access_i           (lu_access),
    .lu_asid_i             (lu_asid),
    .lu_vaddr_i            (lu_vaddr),
    .lu_content_o          (lu_content),
    .asid_to_be_flushed_i  (fl_asid),
    .vaddr_to_be_flushed_i (fl_vaddr),
    .lu_is_4M_o            (lu_is_4M),
    .lu_hit_o              (lu_hit)
  );

  // Behavioural model: one record per entry plus the PLRU node bits.
  bit        m_valid [N];
  bit        m_4m    [N];
  int        m_vpn1  [N];
  int        m_vpn0  [N];
  int        m_asid  [N];
  bit [31:0] m_pte   [N];
  bit        m_plru  [N-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic int node_of(int e, int l);
    return (1 << l) - 1 + (e >> (LOG - l));
  endfunction

  function automatic int dir_of(int e, int l);
    return (e >> (LOG - 1 - l)) & 1;
  endfunction

  function automatic int m_hit_idx();
    int h = -1;
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && (m_asid[i] == int'(lu_asid) || m_pte[i][5])
          && m_vpn1[i] == int'(lu_vaddr[31:22])
          && (m_4m[i] || m_vpn0[i] == int'(lu_vaddr[21:12])))
        h = i;
    end
    return h;
  endfunction

  // The PLRU victim is the one entry whose whole root-to-leaf path points at it.
  function automatic int m_victim();
    for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
    for (int e = 0; e < N; e++) begin
      bit ok = 1'b1;
      for (int l = 0; l < LOG; l++)
        if (int'(m_plru[node_of(e, l)]) != dir_of(e, l)) ok = 1'b0;
      if (ok) return e;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_4m[i] = 0; m_vpn1[i] = 0; m_vpn0[i] = 0; m_asid[i] = 0; m_pte[i] = 0;
    end
    for (int i = 0; i < N - 1; i++) m_plru[i] = 0;
  endtask

  task automatic model_step(input int h);
    int v;
    bit aZ, vZ, addr_m, asid_m, inval;
    v  = m_victim();
    aZ = (fl_asid == 0);
    vZ = (fl_vaddr == 0);
    if (flush) begin
      for (int i = 0; i < N; i++) begin
        addr_m = (m_vpn1[i] == int'(fl_vaddr[31:22])) && (m_4m[i] || m_vpn0[i] == int'(fl_vaddr[21:12]));
        asid_m = (m_asid[i] == int'(fl_asid));
        if (aZ && vZ)  inval = 1;
        else if (aZ)   inval = addr_m;
        else if (vZ)   inval = asid_m && !m_pte[i][5];
        else           inval = addr_m && asid_m && !m_pte[i][5];
        if (inval) m_valid[i] = 0;
      end
    end else if (update[62]) begin
      m_valid[v] = 1;
      m_4m[v]    = update[61];
      m_vpn1[v]  = int'(update[60:51]);
      m_vpn0[v]  = int'(update[50:41]);
      m_asid[v]  = int'(update[40:32]) & ((1 << AW) - 1);
      m_pte[v]   = update[31:0];
    end
    if (lu_access && h >= 0)
      for (int l = 0; l < LOG; l++) m_plru[node_of(h, l)] = !dir_of(h, l);
  endtask

  always @(negedge clk) begin
    int h;
    if (!rst_n) begin
      model_reset();
    end else begin
      h = m_hit_idx();
      chk("model_hit", {31'b0, lu_hit}, (h >= 0) ? 32'd1 : 32'd0);
      chk("model_content", lu_content, (h >= 0) ? m_pte[h] : 32'd0);
      chk("model_is4M", {31'b0, lu_is_4M}, (h >= 0) ? {31'b0, m_4m[h]} : 32'd0);
      model_step(h);
    end
  end

  function automatic logic [62:0] mk_upd(bit is4m, int vpn1, int vpn0, int asid, logic [31:0] pte);
    return {1'b1, is4m, 10'(vpn1), 10'(vpn0), 9'(asid), pte};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input bit eh, input logic [31:0] ec, input bit e4);
    @(negedge clk);
    chk({name, "_hit"}, {31'b0, lu_hit}, {31'b0, eh});
    chk({name, "_content"}, lu_content, ec);
    chk({name, "_is4M"}, {31'b0, lu_is_4M}, {31'b0, e4});
  endtask

  task automatic look(input logic [31:0] va, input int asid, input bit acc);
    lu_vaddr  = va;
    lu_asid   = AW'(asid);
    lu_access = acc;
  endtask

  initial begin
    int order [3] = '{0, 2, 1};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Empty TLB after reset
    look(32'h0000A000, 1, 0);
    lit("reset_lookup", 0, 32'h0, 0);
    tick();

    update = mk_upd(0, 0, 'hA, 1, 32'hFFFFFFFF);
    tick();
    update = '0;
    lit("basic_hit", 1, 32'hFFFFFFFF, 0);
    tick();

    flush = 1; fl_asid = 0; fl_vaddr = 0;
    tick();
    flush = 0;
    lit("flush_all", 0, 32'h0, 0);
    tick();

    // 4 MiB superpage
    update = mk_upd(1, 1, 0, 1, 32'h00000001);
    look(32'h004FF000, 1, 0);
    tick();
    update = '0;
    lit("super_hit", 1, 32'h1, 1);
    tick();
    flush = 1; fl_asid = 1; fl_vaddr = 32'h00400000;
    tick();
    flush = 0; fl_vaddr = 0;
    lit("super_flushed", 0, 32'h0, 0);
    tick();

    // Global entry survives an ASID flush
    update = mk_upd(0, 2, 3, 1, 32'h00000021);
    look(32'h00803000, 0, 0);
    tick();
    update = '0;
    lit("global_hit", 1, 32'h21, 0);
    tick();
    flush = 1; fl_asid = 1; fl_vaddr = 0;
    tick();
    flush = 0;
    lit("global_survives", 1, 32'h21, 0);
    tick();
    flush = 1; fl_asid = 0; fl_vaddr = 0;
    tick();
    flush = 0;

    // Replacement: fill, touch three entries, refill a fifth page
    for (int k = 0; k < 4; k++) begin
      update = mk_upd(0, 16 + k, 0, 0, ((k + 1) << 12) | 1);
      tick();
    end
    update = '0;
    foreach (order[j]) begin
      look((16 + order[j]) << 22, 0, 1);
      lit("touch", 1, ((order[j] + 1) << 12) | 1, 0);
      tick();
    end
    look(32'h0, 0, 0);
    update = mk_upd(0, 32, 0, 0, 32'h00055001);
    tick();
    update = '0;
    look(19 << 22, 0, 0);
    lit("plru_evicted", 0, 32'h0, 0);
    tick();
    look(16 << 22, 0, 0);
    lit("plru_kept", 1, 32'h00001001, 0);
    tick();
    look(32 << 22, 0, 0);
    lit("plru_new", 1, 32'h00055001, 0);
    tick();

    // Update dropped when a flush arrives in the same cycle
    flush = 1; fl_asid = 1; fl_vaddr = 32'hFFFFF000;
    update = mk_upd(0, 48, 0, 0, 32'h00030001);
    tick();
    flush = 0; fl_asid = 0; fl_vaddr = 0; update = '0;
    look(48 << 22, 0, 0);
    lit("upd_dropped", 0, 32'h0, 0);
    tick();
    look(16 << 22, 0, 0);
    lit("flush_no_match", 1, 32'h00001001, 0);
    tick();

    // Asynchronous reset mid-cycle discards all entries
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    lit("midreset", 0, 32'h0, 0);
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        #2 rst_n = 1'b0;
      end else if (c == 1502) begin
        rst_n = 1'b1;
      end
      update = ($urandom_range(0, 9) < 4)
             ? mk_upd($urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 511), $urandom)
             : '0;
      flush    = ($urandom_range(0, 19) == 0);
      fl_asid  = AW'($urandom_range(0, 1));
      fl_vaddr = ($urandom_range(0, 1) == 0) ? 32'h0
               : {10'($urandom_range(0, 3)), 10'($urandom_range(0, 3)), 12'($urandom)};
      look({10'($urandom_range(0, 3)), 10'($urandom_range(0, 3)), 12'($urandom)},
           $urandom_range(0, 1), $urandom_range(0, 1) == 1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
